// File: rtl/multiple_of_three_tx.sv
`default_nettype none
// ============================================================================
// Module   : multiple_of_three_tx
// Brief    : MSB-first parallel-to-serial transmitter with a running mod-3
//            remainder of the bits sent so far. Tracker enabled by the
//            MOD3_TRACK_EN macro; without it rem/exp_div are tied to 0.
// Revision : 1.0  initial release
// ============================================================================
module multiple_of_three_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  output logic             last,
  output logic [1:0]       rem,
  output logic             exp_div
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_SHIFT = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             accept;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);
  assign accept   = in_valid && in_ready;

  // ready in idle, and during the last bit so words can chain without a gap
  always_comb begin
    in_ready = 1'b0;
    if (state_q == ST_IDLE) begin
      in_ready = 1'b1;
    end else if (cnt_zero) begin
      in_ready = 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_zero && !accept) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    out_valid = 1'b0;
    out       = 1'b0;
    last      = 1'b0;
    if (state_q == ST_SHIFT) begin
      out_valid = 1'b1;
      out       = shreg_q[WIDTH-1];
      last      = cnt_zero;
    end
  end

  // Datapath: shift register and bit counter
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (accept) begin
      shreg_d = in_data;
      cnt_d   = CNT_LAST;
    end else if (state_q == ST_SHIFT) begin
      if (!cnt_zero) begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q - CNT_ONE;
      end else begin
        shreg_d = '0;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

`ifdef MOD3_TRACK_EN
  // acc_q holds the remainder of the prefix before the bit now on out
  logic [1:0] acc_q, acc_d;
  logic [1:0] rem_cur;

  function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
    logic [1:0] res;
    case ({r, b})
      3'b000:  res = 2'd0;
      3'b001:  res = 2'd1;
      3'b010:  res = 2'd2;
      3'b011:  res = 2'd0;
      3'b100:  res = 2'd1;
      3'b101:  res = 2'd2;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

  always_comb begin
    rem_cur = 2'd0;
    if (out_valid) begin
      rem_cur = mod3_step(acc_q, out);
    end
  end

  always_comb begin
    acc_d = 2'd0;
    if (accept) begin
      acc_d = 2'd0;
    end else if (out_valid) begin
      acc_d = rem_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= 2'd0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign rem     = rem_cur;
  assign exp_div = out_valid && (rem_cur == 2'd0);
`else
  assign rem     = 2'd0;
  assign exp_div = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multiple_of_three_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiple_of_three_tx
// Brief    : Directed self-checking bench for multiple_of_three_tx (WIDTH=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_multiple_of_three_tx;

`ifdef MOD3_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out;
  logic       out_valid;
  logic       last;
  logic [1:0] rem;
  logic       exp_div;

  int tests = 0;
  int fails = 0;

  multiple_of_three_tx #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .last      (last),
    .rem       (rem),
    .exp_div   (exp_div)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL %s out_valid: got %b want 0", tag, out_valid); end
    tests++;
    if (out !== 1'b0) begin fails++; $display("FAIL %s out: got %b want 0", tag, out); end
    tests++;
    if (last !== 1'b0) begin fails++; $display("FAIL %s last: got %b want 0", tag, last); end
    tests++;
    if (rem !== 2'd0) begin fails++; $display("FAIL %s rem: got %0d want 0", tag, rem); end
    tests++;
    if (exp_div !== 1'b0) begin fails++; $display("FAIL %s exp_div: got %b want 0", tag, exp_div); end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL %s in_ready: got %b want 1", tag, in_ready); end
  endtask

  task automatic offer(input logic [7:0] w);
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL offer_%02h in_ready: got %b want 1", w, in_ready); end
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  // Checks the 8 bit-cycles of w (MSB already on out). in_valid is driven
  // high with nw for bit indices from..to.
  task automatic stream_word(input logic [7:0] w, input logic [7:0][1:0] er,
                             input int from, input int to, input logic [7:0] nw);
    logic [1:0] erem;
    logic       ediv;
    for (int i = 0; i < 8; i++) begin
      erem = TRACK ? er[7-i] : 2'd0;
      ediv = TRACK && (er[7-i] == 2'd0);
      tests++;
      if (out !== w[7-i]) begin fails++; $display("FAIL w%02h bit%0d out: got %b want %b", w, i, out, w[7-i]); end
      tests++;
      if (out_valid !== 1'b1) begin fails++; $display("FAIL w%02h bit%0d out_valid: got %b want 1", w, i, out_valid); end
      tests++;
      if (last !== (i == 7)) begin fails++; $display("FAIL w%02h bit%0d last: got %b want %b", w, i, last, (i == 7)); end
      tests++;
      if (rem !== erem) begin fails++; $display("FAIL w%02h bit%0d rem: got %0d want %0d", w, i, rem, erem); end
      tests++;
      if (exp_div !== ediv) begin fails++; $display("FAIL w%02h bit%0d exp_div: got %b want %b", w, i, exp_div, ediv); end
      tests++;
      if (in_ready !== (i == 7)) begin fails++; $display("FAIL w%02h bit%0d in_ready: got %b want %b", w, i, in_ready, (i == 7)); end
      in_valid = (i >= from) && (i <= to);
      in_data  = nw;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    check_idle("reset");
    reset = 1'b0;
    tick();
    check_idle("post_reset");
  endtask

  task automatic test_single_words();
    offer(8'h06);
    stream_word(8'h06, {2'd0,2'd0,2'd0,2'd0,2'd0,2'd1,2'd0,2'd0}, 8, 8, 8'h00);
    check_idle("after_06");
    offer(8'h07);
    stream_word(8'h07, {2'd0,2'd0,2'd0,2'd0,2'd0,2'd1,2'd0,2'd1}, 8, 8, 8'h00);
    check_idle("after_07");
    offer(8'hFF);
    stream_word(8'hFF, {2'd1,2'd0,2'd1,2'd0,2'd1,2'd0,2'd1,2'd0}, 8, 8, 8'h00);
    check_idle("after_FF");
  endtask

  task automatic test_back_to_back();
    offer(8'hA5);
    stream_word(8'hA5, {2'd1,2'd2,2'd2,2'd1,2'd2,2'd2,2'd1,2'd0}, 0, 7, 8'h03);
    stream_word(8'h03, {2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd1,2'd0}, 8, 8, 8'h00);
    check_idle("after_b2b");
  endtask

  task automatic test_ignore_busy();
    offer(8'h81);
    stream_word(8'h81, {2'd1,2'd2,2'd1,2'd2,2'd1,2'd2,2'd1,2'd0}, 3, 3, 8'hFF);
    check_idle("after_81");
    tick();
    check_idle("idle_81");
  endtask

  task automatic test_reset_mid_word();
    logic [7:0]       w;
    logic [3:0][1:0]  er;
    w  = 8'hC3;
    er = {2'd1,2'd0,2'd0,2'd0};
    offer(w);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (out !== w[7-i]) begin fails++; $display("FAIL wC3 bit%0d out: got %b want %b", i, out, w[7-i]); end
      tests++;
      if (rem !== (TRACK ? er[3-i] : 2'd0)) begin
        fails++; $display("FAIL wC3 bit%0d rem: got %0d want %0d", i, rem, (TRACK ? er[3-i] : 2'd0));
      end
      tick();
    end
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL wC3 bit4 out_valid: got %b want 1", out_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("mid_reset");
    tick();
    check_idle("mid_reset_hold");
    // reset wins over a simultaneous accept
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h55;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    check_idle("reset_prio");
    tick();
    check_idle("reset_prio_drop");
    offer(8'h09);
    stream_word(8'h09, {2'd0,2'd0,2'd0,2'd0,2'd1,2'd2,2'd1,2'd0}, 8, 8, 8'h00);
    check_idle("after_09");
  endtask

  initial begin
    test_reset();
    test_single_words();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_word();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
